// File: rtl/spart_divisor_loader.sv
// Loads the SPART baud divisor after reset or on request, waits for isReady,
// then arbitrates the SPART bus between the loader and the host.
module spart_divisor_loader #(
  parameter logic [15:0] DIV0        = 16'h028A,
  parameter logic [15:0] DIV1        = 16'h0144,
  parameter logic [15:0] DIV2        = 16'h00A2,
  parameter logic [15:0] DIV3        = 16'h0050,
  parameter int          RDY_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] br_cfg,
  input  logic       reconfig,
  input  logic       host_iocs,
  input  logic       host_iorw,
  input  logic [1:0] host_ioaddr,
  input  logic [7:0] host_data,
  input  logic       isReady,
  output logic       iocs,
  output logic       iorw,
  output logic [1:0] ioaddr,
  output logic [7:0] dataOut,
  output logic       cfg_done,
  output logic       cfg_err,
  output logic       host_stall,
  output logic       host_blocked
);

  localparam int CW = (RDY_TIMEOUT > 2) ? $clog2(RDY_TIMEOUT) : 1;

  typedef enum logic [1:0] {LOAD_LO, LOAD_HI, WAIT_RDY, IDLE} state_t;

  state_t        r_state, w_state_nxt;
  logic          r_pending, w_pending_nxt;
  logic [1:0]    r_cfg_q, w_cfg_q_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_done, w_done_nxt;
  logic          r_err, w_err_nxt;
  logic          r_iocs, w_iocs_nxt;
  logic          r_iorw, w_iorw_nxt;
  logic [1:0]    r_ioaddr, w_ioaddr_nxt;
  logic [7:0]    r_data, w_data_nxt;
  logic [1:0]    w_div_sel;
  logic [15:0]   w_div;
  logic          w_idle;
  logic          w_blk;

  // LOAD_LO picks the live switch setting; LOAD_HI must use the latched one
  assign w_div_sel = (r_state == LOAD_LO) ? br_cfg : r_cfg_q;

  always_comb begin
    case (w_div_sel)
      2'd0:    w_div = DIV0;
      2'd1:    w_div = DIV1;
      2'd2:    w_div = DIV2;
      default: w_div = DIV3;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= LOAD_LO;
      r_pending <= 1'b0;
      r_cfg_q   <= 2'b00;
      r_cnt     <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_iocs    <= 1'b0;
      r_iorw    <= 1'b1;
      r_ioaddr  <= 2'b00;
      r_data    <= 8'h00;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pending_nxt;
      r_cfg_q   <= w_cfg_q_nxt;
      r_cnt     <= w_cnt_nxt;
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
      r_iocs    <= w_iocs_nxt;
      r_iorw    <= w_iorw_nxt;
      r_ioaddr  <= w_ioaddr_nxt;
      r_data    <= w_data_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pending_nxt = r_pending | reconfig;
    w_cfg_q_nxt   = r_cfg_q;
    w_cnt_nxt     = r_cnt;
    w_done_nxt    = r_done;
    w_err_nxt     = r_err;
    w_iocs_nxt    = 1'b0;
    w_iorw_nxt    = 1'b1;
    w_ioaddr_nxt  = 2'b00;
    w_data_nxt    = 8'h00;
    case (r_state)
      LOAD_LO: begin
        w_cfg_q_nxt  = br_cfg;
        w_iocs_nxt   = 1'b1;
        w_iorw_nxt   = 1'b0;
        w_ioaddr_nxt = 2'b10;
        w_data_nxt   = w_div[7:0];
        w_done_nxt   = 1'b0;
        w_state_nxt  = LOAD_HI;
      end
      LOAD_HI: begin
        w_iocs_nxt   = 1'b1;
        w_iorw_nxt   = 1'b0;
        w_ioaddr_nxt = 2'b11;
        w_data_nxt   = w_div[15:8];
        w_cnt_nxt    = '0;
        w_state_nxt  = WAIT_RDY;
      end
      WAIT_RDY: begin
        w_cnt_nxt = r_cnt + 1'b1;
        // isReady wins over a coincident timeout
        if (isReady) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end else if (r_cnt == CW'(RDY_TIMEOUT - 1)) begin
          w_err_nxt   = 1'b1;
          w_done_nxt  = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        if (r_pending || reconfig || (br_cfg != r_cfg_q)) begin
          w_pending_nxt = 1'b0;
          w_state_nxt   = LOAD_LO;
        end
      end
    endcase
  end

  assign w_idle = (r_state == IDLE);
  assign w_blk  = w_idle & host_iocs & ~host_iorw & host_ioaddr[1];

  assign iocs         = w_idle ? (host_iocs & ~w_blk) : r_iocs;
  assign iorw         = w_idle ? host_iorw   : r_iorw;
  assign ioaddr       = w_idle ? host_ioaddr : r_ioaddr;
  assign dataOut      = w_idle ? host_data   : r_data;
  assign cfg_done     = r_done;
  assign cfg_err      = r_err;
  assign host_stall   = ~w_idle;
  assign host_blocked = w_blk;

endmodule
